serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial N-bit adder controller. It time-multiplexes one 1-bit adder cell across all operand bits, LSB first, with a carry flip-flop between cycles. A start/busy/done handshake sequences each operation. It sits between a requester that supplies operand words and the mux-built adder cells, trading latency for area.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk    input   1      clock, all logic on rising edge
rst    input   1      synchronous active-high reset
start  input   1      request a new operation; sampled only in IDLE or DONE
a      input   WIDTH  operand A; captured on the accepted start edge
b      input   WIDTH  operand B; captured on the accepted start edge
busy   output  1      high while in RUN
done   output  1      one-cycle pulse when sum/cout become valid
sum    output  WIDTH  result; holds its value from done until the next accepted start
cout   output  1      carry out of MSB; held with sum

Behaviour:
- Reset is synchronous and active-high: rst high at a rising clk edge forces the reset state.
  - Reset state: IDLE, busy=0, done=0, sum=0, cout=0, carry=0, bit counter=0, operand shift registers=0.
  - Reset mid-RUN aborts the operation. No done is issued. sum/cout are cleared.
- FSM states: IDLE, RUN, DONE, held in a 2-bit state register.
  - IDLE: if start, load a/b into shift registers, carry=0, cnt=0, go to RUN. Otherwise stay.
  - RUN: busy=1. Each cycle:
    - bit_sum = a_sr[0]^b_sr[0]^carry, computed by the adder cell.
    - Shift bit_sum into sum_sr at the MSB end, shifting right.
    - carry = cell carry-out.
    - Shift a_sr and b_sr right by 1.
    - cnt++.
    - When cnt==WIDTH-1, the next state is DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. sum = completed sum_sr and cout = carry, both registered on entry to DONE.
    - If start is high in DONE, capture new operands and go straight to RUN (back-to-back). Otherwise go to IDLE.
- Latency: start accepted at edge T0. RUN occupies edges T1..T(WIDTH). done is high in the cycle after edge T(WIDTH). Total WIDTH+1 cycles from start to done.
- Throughput: one operation per WIDTH+1 cycles with back-to-back start.
- start while busy is ignored. It is neither queued nor able to corrupt the operation.
- Operand inputs a/b are don't-care except on the accepted start edge.
- Wrap-around: the WIDTH-bit sum wraps modulo 2^WIDTH; the overflow bit appears only on cout.
- cnt is $clog2(WIDTH) bits wide and is never compared beyond WIDTH-1.
- sum/cout update only on entry to DONE. They are stable during RUN and remain at the previous result.

Optional Feature:
Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands on the accepted start.
  - When sub=1, b is inverted on load and the initial carry is 1, so sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow (a >= b unsigned).
  - sub=0 behaves identically to the macro-undefined build.
- Undefined: no sub port; add only.

Decomposition:
- Shared package/include serial_add_pkg with:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- One sub-module: full_add_mux, a 1-bit full adder built from two half-adder mux cells plus an OR for carry. It is instantiated once as the serial datapath cell.
- The controller holds the FSM, counter, shift registers and carry flop.

Test Plan (WIDTH=8):
1. rst=1 for 2 cycles, then release. Expect busy=0, done=0, sum=8'h00, cout=0. Apply a=8'h05, b=8'h03, start=1 for one cycle. Expect busy high for 8 cycles, done pulse on cycle 9, sum=8'h08, cout=0.
2. a=8'hFF, b=8'h01, start. Expect sum=8'h00, cout=1. Also a=8'hAA, b=8'h55: expect sum=8'hFF, cout=0.
3. During busy, pulse start with a=8'h10, b=8'h10. Expect it ignored: the result is from the original operands, and exactly one done pulse.
4. Hold start high through done with new a=8'h7F, b=8'h01. Expect the second op to enter RUN directly from DONE, done pulses exactly 9 cycles apart, second sum=8'h80, cout=0.
5. Assert rst at RUN cycle 4. Expect the next cycle to show IDLE, busy=0, sum=8'h00, and no done. A new start then works normally (8'h01+8'h01 gives 8'h02).
6. With SERIAL_ADD_SUB_EN:
   - sub=1, a=8'h05, b=8'h03: expect sum=8'h02, cout=1.
   - sub=1, a=8'h03, b=8'h05: expect sum=8'hFE, cout=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_add_mux.sv
// 1-bit full adder built from two mux-based half-adder cells and an OR for
// the carry; used once as the serial datapath cell.
module full_add_mux (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    // Each half adder is a pair of 2:1 muxes selected by its first input.
    assign s1   = a  ? ~b   : b;
    assign c1   = a  ? b    : 1'b0;
    assign sum  = s1 ? ~cin : cin;
    assign c2   = s1 ? cin  : 1'b0;
    assign cout = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller, LSB first, start/busy/done handshake.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input for a - b.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_sum;
    logic             bit_cout;
    logic [WIDTH-1:0] next_sum;
    logic [WIDTH-1:0] load_b;
    logic             load_carry;

    // Subtraction is a + ~b + 1, so only the loaded B and initial carry differ.
`ifdef SERIAL_ADD_SUB_EN
    assign load_b     = sub ? ~b : b;
    assign load_carry = sub;
`else
    assign load_b     = b;
    assign load_carry = 1'b0;
`endif

    full_add_mux u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (bit_sum),
        .cout (bit_cout)
    );

    assign next_sum = {bit_sum, sum_sr[WIDTH-1:1]};

    // Controller FSM; busy/done/sum/cout are all registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= load_b;
                        carry <= load_carry;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_sr <= next_sum;
                    carry  <= bit_cout;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= next_sum;
                        cout  <= bit_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    // A start seen here skips IDLE for back-to-back throughput.
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= load_b;
                        carry <= load_carry;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8; subtract tests
// are included when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse, then count busy cycles until done (bounded).
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          output int busy_cnt, output int done_cyc);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = 0;
        done_cyc = 1;
        while (!done && done_cyc < 40) begin
            if (busy) busy_cnt++;
            tick();
            done_cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                     busy, done, sum, cout);
        end
    endtask

    task automatic test_basic_add();
        int bc, dc;
        run_op(8'h05, 8'h03, bc, dc);
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles got %0d want 8", bc);
        end
        checks++;
        if (dc !== 9) begin
            errors++;
            $display("[TB] FAIL basic_done_cycle got %0d want 9", dc);
        end
        checks++;
        if ({sum, cout} !== {8'h08, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_result got sum=%h cout=%b want 08 0", sum, cout);
        end
        tick();
        checks++;
        if ({done, busy, sum} !== {1'b0, 1'b0, 8'h08}) begin
            errors++;
            $display("[TB] FAIL basic_after_done got done=%b busy=%b sum=%h want 0 0 08",
                     done, busy, sum);
        end
    endtask

    task automatic test_wrap();
        int bc, dc;
        run_op(8'hFF, 8'h01, bc, dc);
        checks++;
        if ({sum, cout} !== {8'h00, 1'b1} || dc !== 9) begin
            errors++;
            $display("[TB] FAIL wrap_ff_01 got sum=%h cout=%b cyc=%0d want 00 1 9", sum, cout, dc);
        end
        tick();
        run_op(8'hAA, 8'h55, bc, dc);
        checks++;
        if ({sum, cout} !== {8'hFF, 1'b0} || dc !== 9) begin
            errors++;
            $display("[TB] FAIL add_aa_55 got sum=%h cout=%b cyc=%0d want ff 0 9", sum, cout, dc);
        end
        tick();
        run_op(8'h80, 8'h80, bc, dc);
        checks++;
        if ({sum, cout} !== {8'h00, 1'b1}) begin
            errors++;
            $display("[TB] FAIL wrap_80_80 got sum=%h cout=%b want 00 1", sum, cout);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        logic sum_stable = 1'b1;
        a = 8'h21;
        b = 8'h12;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sum !== 8'h00 || cout !== 1'b1) sum_stable = 1'b0;
            tick();
        end
        a = 8'h10;
        b = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                pulses++;
                checks++;
                if ({sum, cout} !== {8'h33, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL ignore_result got sum=%h cout=%b want 33 0", sum, cout);
                end
            end else if (busy && (sum !== 8'h00 || cout !== 1'b1)) begin
                sum_stable = 1'b0;
            end
            tick();
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("[TB] FAIL ignore_done_count got %0d want 1", pulses);
        end
        checks++;
        if (sum_stable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_holds_prev_result got changed want held 00/1");
        end
    endtask

    task automatic test_back_to_back();
        int gap = 0;
        int guard = 0;
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        tick();
        a = 8'h7F;
        b = 8'h01;
        while (!done && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if ({done, sum, cout} !== {1'b1, 8'h46, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_first got done=%b sum=%h cout=%b want 1 46 0", done, sum, cout);
        end
        tick();
        start = 1'b0;
        gap = 1;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL b2b_direct_run got busy=%b done=%b want 1 0", busy, done);
        end
        while (!done && gap < 40) begin
            tick();
            gap++;
        end
        checks++;
        if (gap !== 9) begin
            errors++;
            $display("[TB] FAIL b2b_done_spacing got %0d want 9", gap);
        end
        checks++;
        if ({sum, cout} !== {8'h80, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_second got sum=%h cout=%b want 80 0", sum, cout);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        int bc, dc;
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                     busy, done, sum, cout);
        end
        for (int i = 0; i < 12; i++) begin
            if (done || busy) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL midrun_no_done got %0d active cycles want 0", pulses);
        end
        run_op(8'h01, 8'h01, bc, dc);
        checks++;
        if ({sum, cout} !== {8'h02, 1'b0} || dc !== 9) begin
            errors++;
            $display("[TB] FAIL after_reset_op got sum=%h cout=%b cyc=%0d want 02 0 9", sum, cout, dc);
        end
        tick();
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int bc, dc;
        sub = 1'b1;
        run_op(8'h05, 8'h03, bc, dc);
        checks++;
        if ({sum, cout} !== {8'h02, 1'b1}) begin
            errors++;
            $display("[TB] FAIL sub_05_03 got sum=%h cout=%b want 02 1", sum, cout);
        end
        tick();
        run_op(8'h03, 8'h05, bc, dc);
        checks++;
        if ({sum, cout} !== {8'hFE, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sub_03_05 got sum=%h cout=%b want fe 0", sum, cout);
        end
        tick();
        sub = 1'b0;
        run_op(8'h05, 8'h03, bc, dc);
        checks++;
        if ({sum, cout} !== {8'h08, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sub0_add got sum=%h cout=%b want 08 0", sum, cout);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_add();
        test_wrap();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
